dm_port_arbiter: RTL and testbench

Arbitrates the single data-memory block-RAM port between the pipeline's MEM stage and a secondary requester (DMA / debug loader). The CPU has priority; a starvation counter forces a DMA slot when the secondary port has waited too long, stalling the pipeline for exactly that cycle. It sits between the MEM stage and the data RAM and tracks port ownership so read data returning one cycle later is routed as a DMA read-valid strobe.

---
 rtl/dm_arb_pkg.sv | 35 +++
 rtl/dm_starve_cnt.sv | 40 ++++
 rtl/dm_port_arbiter.sv | 113 +++++++++++
 tb/tb_dm_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// Holds the owner encoding, the request bundle and the owner-selection helper.
package dm_arb_pkg;

    localparam int unsigned DM_AW       = 12;
    localparam int unsigned DM_STARVE_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } dm_owner_t;

    // Address field is DM_AW wide; narrower top-level AW values are zero-extended into it.
    typedef struct packed {
        logic [3:0]       be;
        logic [DM_AW-1:0] addr;
        logic [31:0]      wdata;
    } dm_req_t;

    // DMA takes the port when the CPU is idle or a starvation slot is forced.
    function automatic dm_owner_t dm_pick_owner(input logic cpu_en,
                                                input logic dma_req,
                                                input logic force_slot);
        dm_owner_t owner;
        owner = OWN_NONE;
        if (dma_req && (!cpu_en || force_slot)) begin
            owner = OWN_DMA;
        end else if (cpu_en) begin
            owner = OWN_CPU;
        end
        return owner;
    endfunction

endpackage

// File: rtl/dm_starve_cnt.sv
// Saturating starvation counter for the secondary port.
// Counts cycles of denied DMA requests; hit flags that the limit has been reached.
module dm_starve_cnt
    import dm_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic hit
);

    logic [DM_STARVE_W-1:0] cnt_q, cnt_d;
    logic [DM_STARVE_W-1:0] limit_val;

    assign limit_val = DM_STARVE_W'(LIMIT);

    // Next count: clear on grant or no request, otherwise saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != limit_val) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == limit_val);

endmodule

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter between the MEM stage (priority) and a DMA/debug requester.
// Optional feature macro: DM_ARB_STARVE_EN enables the starvation counter and forced
// DMA slot; without it the CPU has strict priority and cpu_stall is never raised.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned AW           = DM_AW,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    // MEM stage
    input  logic          cpu_en,
    input  logic [3:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_stall,
    // Secondary requester
    input  logic          dma_req,
    input  logic [3:0]    dma_be,
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [31:0]   dma_rdata,
    // RAM port
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    dm_req_t   cpu_req, dma_req_s, own_req;
    dm_owner_t owner;
    logic      force_slot;
    logic      rd_dma_q, rd_dma_d;

    assign cpu_req   = '{be: cpu_be, addr: DM_AW'(cpu_addr), wdata: cpu_wdata};
    assign dma_req_s = '{be: dma_be, addr: DM_AW'(dma_addr), wdata: dma_wdata};

`ifdef DM_ARB_STARVE_EN
    logic starve_hit;

    dm_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .clr (dma_gnt || !dma_req),
        .hit (starve_hit)
    );

    assign force_slot = starve_hit && dma_req;
`else
    logic unused_starve_limit;

    assign unused_starve_limit = ^DM_STARVE_W'(STARVE_LIMIT);
    assign force_slot          = 1'b0;
`endif

    // Owner selection; the port is held idle while reset is asserted.
    always_comb begin
        owner = OWN_NONE;
        if (rst) begin
            owner = dm_pick_owner(cpu_en, dma_req, force_slot);
        end
    end

    // Drive the RAM port from the owner's request fields.
    always_comb begin
        own_req = '0;
        ram_en  = 1'b0;
        case (owner)
            OWN_CPU: begin
                own_req = cpu_req;
                ram_en  = 1'b1;
            end
            OWN_DMA: begin
                own_req = dma_req_s;
                ram_en  = 1'b1;
            end
            default: begin
                own_req = '0;
                ram_en  = 1'b0;
            end
        endcase
        ram_we    = own_req.be;
        ram_addr  = AW'(own_req.addr);
        ram_wdata = own_req.wdata;
    end

    assign dma_gnt   = (owner == OWN_DMA);
    assign cpu_stall = rst && cpu_en && force_slot;

    // A granted DMA read expects its data on the next cycle.
    always_comb begin
        rd_dma_d = dma_gnt && (dma_be == 4'b0000);
    end

    // Read-tracking register; reset drops any pending read-valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dma_q <= 1'b0;
        end else begin
            rd_dma_q <= rd_dma_d;
        end
    end

    assign dma_rvalid = rd_dma_q;
    assign dma_rdata  = ram_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter with a one-cycle-latency RAM model.
// Expectations follow DM_ARB_STARVE_EN when it is defined for the build.
module tb_dm_port_arbiter;

    localparam int unsigned AW = 12;
`ifdef DM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_en;
    logic [3:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic          dma_req;
    logic [3:0]    dma_be;
    logic [AW-1:0] dma_addr;
    logic [31:0]   dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [31:0]   dma_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(
        .AW           (AW),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_en     (cpu_en),
        .cpu_be     (cpu_be),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_be     (dma_be),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Byte-enabled synchronous RAM, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

`ifdef DM_ARB_STARVE_EN
    logic          l1_cpu_en, l1_dma_req, l1_stall, l1_gnt, l1_rvalid, l1_ram_en;
    logic [31:0]   l1_rdata, l1_ram_wdata;
    logic [3:0]    l1_ram_we;
    logic [AW-1:0] l1_ram_addr;

    dm_port_arbiter #(
        .AW           (AW),
        .STARVE_LIMIT (1)
    ) dut_l1 (
        .clk        (clk),
        .rst        (rst),
        .cpu_en     (l1_cpu_en),
        .cpu_be     (4'b0000),
        .cpu_addr   (12'h040),
        .cpu_wdata  (32'h0),
        .cpu_stall  (l1_stall),
        .dma_req    (l1_dma_req),
        .dma_be     (4'b1111),
        .dma_addr   (12'h050),
        .dma_wdata  (32'h1234_5678),
        .dma_gnt    (l1_gnt),
        .dma_rvalid (l1_rvalid),
        .dma_rdata  (l1_rdata),
        .ram_en     (l1_ram_en),
        .ram_we     (l1_ram_we),
        .ram_addr   (l1_ram_addr),
        .ram_wdata  (l1_ram_wdata),
        .ram_rdata  (32'h0)
    );
`endif

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_en  = 1'b0;
        dma_req = 1'b0;
        cpu_be  = 4'b0000;
        dma_be  = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_en = 1'b1; dma_req = 1'b1; cpu_addr = 12'h001; dma_addr = 12'h002;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", dma_gnt); end
        if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
        if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got %b want 0", ram_en); end
        if (ram_we !== 4'b0000) begin errors++; $display("FAIL reset_ram_we got %b want 0000", ram_we); end
        if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", dma_rvalid); end
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_dma_read();
        cpu_en = 1'b0; dma_req = 1'b1; dma_be = 4'b0000; dma_addr = 12'h010;
        @(negedge clk);
        checks += 4;
        if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b want 1", dma_gnt); end
        if (ram_en !== 1'b1) begin errors++; $display("FAIL rd_ram_en got %b want 1", ram_en); end
        if (ram_addr !== 12'h010) begin errors++; $display("FAIL rd_addr got %h want 010", ram_addr); end
        if (ram_we !== 4'b0000) begin errors++; $display("FAIL rd_we got %b want 0000", ram_we); end
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        checks += 3;
        if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got %b want 1", dma_rvalid); end
        if (dma_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", dma_rdata); end
        if (dma_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt_drop got %b want 0", dma_gnt); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse got %b want 0", dma_rvalid); end
        next_cycle();
    endtask

    task automatic test_contention();
        int  n;
        bit  exp_dma;
        n = STARVE_EN ? 10 : 100;
        cpu_en = 1'b1; cpu_be = 4'b0000; cpu_addr = 12'h100;
        dma_req = 1'b1; dma_be = 4'b0000; dma_addr = 12'h030;
        for (int c = 0; c < n; c++) begin
            exp_dma = STARVE_EN && (c == 8);
            @(negedge clk);
            checks += 3;
            if (dma_gnt !== exp_dma)
                begin errors++; $display("FAIL cont_gnt c%0d got %b want %b", c, dma_gnt, exp_dma); end
            if (cpu_stall !== exp_dma)
                begin errors++; $display("FAIL cont_stall c%0d got %b want %b", c, cpu_stall, exp_dma); end
            if (ram_addr !== (exp_dma ? 12'h030 : 12'h100))
                begin errors++; $display("FAIL cont_addr c%0d got %h", c, ram_addr); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_dma_write_readback();
        cpu_en = 1'b0; dma_req = 1'b1; dma_be = 4'b0011; dma_addr = 12'h020;
        dma_wdata = 32'h0000_ABCD;
        @(negedge clk);
        checks += 2;
        if (dma_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b want 1", dma_gnt); end
        if (ram_we !== 4'b0011) begin errors++; $display("FAIL wr_we got %b want 0011", ram_we); end
        next_cycle();
        dma_req = 1'b0; dma_be = 4'b0000;
        cpu_en = 1'b1; cpu_be = 4'b0000; cpu_addr = 12'h020;
        @(negedge clk);
        checks += 4;
        if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid got %b want 0", dma_rvalid); end
        if (ram_en !== 1'b1) begin errors++; $display("FAIL cpu_rd_en got %b want 1", ram_en); end
        if (ram_we !== 4'b0000) begin errors++; $display("FAIL cpu_rd_we got %b want 0000", ram_we); end
        if (ram_addr !== 12'h020) begin errors++; $display("FAIL cpu_rd_addr got %h want 020", ram_addr); end
        next_cycle();
        cpu_en = 1'b0;
        @(negedge clk);
        checks += 2;
        if (ram_rdata !== 32'hFFFF_ABCD)
            begin errors++; $display("FAIL readback got %h want ffffabcd", ram_rdata); end
        if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_rvalid got %b want 0", dma_rvalid); end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        cpu_en = 1'b0; dma_req = 1'b1; dma_be = 4'b0000; dma_addr = 12'h010;
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b want 1", dma_gnt); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %b want 0", dma_rvalid); end
        if (dma_gnt !== 1'b0) begin errors++; $display("FAIL mid_gnt_rst got %b want 0", dma_gnt); end
        if (ram_en !== 1'b0) begin errors++; $display("FAIL mid_ram_en got %b want 0", ram_en); end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks += 2;
        if (dma_gnt !== 1'b1) begin errors++; $display("FAIL post_gnt got %b want 1", dma_gnt); end
        if (ram_addr !== 12'h010) begin errors++; $display("FAIL post_addr got %h want 010", ram_addr); end
        next_cycle();
        dma_req = 1'b0;
        @(negedge clk);
        checks += 2;
        if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL post_rvalid got %b want 1", dma_rvalid); end
        if (dma_rdata !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL post_data got %h want deadbeef", dma_rdata); end
        next_cycle();
    endtask

`ifdef DM_ARB_STARVE_EN
    task automatic test_limit_one();
        bit exp_dma;
        l1_cpu_en = 1'b1; l1_dma_req = 1'b1;
        for (int c = 0; c < 6; c++) begin
            exp_dma = (c % 2) == 1;
            @(negedge clk);
            checks += 3;
            if (l1_gnt !== exp_dma)
                begin errors++; $display("FAIL l1_gnt c%0d got %b want %b", c, l1_gnt, exp_dma); end
            if (l1_stall !== exp_dma)
                begin errors++; $display("FAIL l1_stall c%0d got %b want %b", c, l1_stall, exp_dma); end
            if (l1_ram_addr !== (exp_dma ? 12'h050 : 12'h040))
                begin errors++; $display("FAIL l1_addr c%0d got %h", c, l1_ram_addr); end
            next_cycle();
        end
        l1_cpu_en = 1'b0; l1_dma_req = 1'b0;
        next_cycle();
    endtask
`endif

    initial begin
        mem[12'h010] = 32'hDEAD_BEEF;
        mem[12'h020] = 32'hFFFF_FFFF;
        ram_rdata = 32'h0;
        cpu_wdata = 32'h0;
        dma_wdata = 32'h0;
        cpu_addr  = '0;
        dma_addr  = '0;
        idle_inputs();
`ifdef DM_ARB_STARVE_EN
        l1_cpu_en = 1'b0; l1_dma_req = 1'b0;
`endif
        test_reset();
        test_dma_read();
        test_contention();
        test_dma_write_readback();
        test_reset_mid_read();
`ifdef DM_ARB_STARVE_EN
        test_limit_one();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
